// File: rtl/pcs_sync_pkg.sv
// Shared 1000BASE-X PCS definitions: sync state encoding, comma patterns and
// the ordered-set code groups used around code-group alignment.
package pcs_sync_pkg;

    typedef enum logic [3:0] {
        LOSS_OF_SYNC,
        COMMA_DETECT_1,
        COMMA_DETECT_2,
        COMMA_DETECT_3,
        ACQUIRE_SYNC_1,
        ACQUIRE_SYNC_2,
        SYNC_ACQUIRED_1,
        SYNC_ACQUIRED_2,
        SYNC_ACQUIRED_3,
        SYNC_ACQUIRED_4,
        SYNC_ACQUIRED_2A,
        SYNC_ACQUIRED_3A,
        SYNC_ACQUIRED_4A
    } pcs_state_t;

    // Seven-bit comma patterns in bits abcdeif (rx_code_group[9:3])
    localparam logic [6:0] COMMA_RDN = 7'b0011111;
    localparam logic [6:0] COMMA_RDP = 7'b1100000;
    localparam logic [9:0] COMMA_MASK = 10'b11_1111_1000;

    localparam logic [9:0] K28_5_RDN = 10'h0FA;
    localparam logic [9:0] K28_5_RDP = 10'h305;
    localparam logic [9:0] D16_2_RDN = 10'h1B5;
    localparam logic [9:0] D16_2_RDP = 10'h245;

    localparam logic [1:0] GOOD_CGS_MAX = 2'd3;

    function automatic logic is_comma_detect(input pcs_state_t s);
        return s inside {COMMA_DETECT_1, COMMA_DETECT_2, COMMA_DETECT_3};
    endfunction

    function automatic logic is_sync_acquired(input pcs_state_t s);
        return s inside {SYNC_ACQUIRED_1, SYNC_ACQUIRED_2, SYNC_ACQUIRED_3,
                         SYNC_ACQUIRED_4, SYNC_ACQUIRED_2A, SYNC_ACQUIRED_3A,
                         SYNC_ACQUIRED_4A};
    endfunction

    function automatic logic is_good_run(input pcs_state_t s);
        return s inside {SYNC_ACQUIRED_2A, SYNC_ACQUIRED_3A, SYNC_ACQUIRED_4A};
    endfunction

endpackage

// File: rtl/pcs_sync_if.sv
// Code-group stream between the PMA/decoder side and the PCS sync block.
interface pcs_sync_if;

    logic       signal_detect;
    logic [9:0] rx_code_group;
    logic       cg_invalid;
    logic       code_sync_status;
    logic       rx_even;
    logic [9:0] rx_code_group_out;
    logic       rx_comma;

    modport master (
        output signal_detect, rx_code_group, cg_invalid,
        input  code_sync_status, rx_even, rx_code_group_out, rx_comma
    );

    modport slave (
        input  signal_detect, rx_code_group, cg_invalid,
        output code_sync_status, rx_even, rx_code_group_out, rx_comma
    );

endinterface

// File: rtl/pcs_comma_detect.sv
// Combinational /COMMA/ detector on a 10-bit code group (bit 9 = a).
module pcs_comma_detect
    import pcs_sync_pkg::*;
(
    input  logic [9:0] code_group,
    output logic       comma
);

    // Only bits abcdeif carry the comma; the mask keeps fghj out of the compare
    assign comma = ((code_group & COMMA_MASK) == {COMMA_RDN, 3'b000}) ||
                   ((code_group & COMMA_MASK) == {COMMA_RDP, 3'b000});

endmodule

// File: rtl/pcs_sync.sv
// 1000BASE-X receive code-group synchronization: comma alignment, sync
// acquisition/loss hysteresis and even/odd tagging of the forwarded stream.
module pcs_sync
    import pcs_sync_pkg::*;
(
    input  logic      GTX_CLK,
    input  logic      mr_main_reset,
    pcs_sync_if.slave rx
);

    pcs_state_t state;
    pcs_state_t state_next;
    logic [1:0] good_cgs;
    logic [1:0] good_cgs_next;
    logic       rx_even_q;
    logic       rx_even_next;
    logic       status_q;
    logic       status_next;
    logic       rx_comma_q;
    logic [9:0] cg_out_q;
    logic       comma;
    logic       data;
    logic       cgbad;

    pcs_comma_detect u_comma_detect (
        .code_group (rx.rx_code_group),
        .comma      (comma)
    );

    // rx_even_q tags the previous group, so the incoming one is odd when it is set
    assign cgbad = rx.cg_invalid | (comma & rx_even_q);
    assign data  = ~comma & ~rx.cg_invalid;

    always_ff @(posedge GTX_CLK or posedge mr_main_reset) begin
        if (mr_main_reset) begin
            state <= LOSS_OF_SYNC;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (!rx.signal_detect) begin
            state_next = LOSS_OF_SYNC;
        end else begin
            case (state)
                LOSS_OF_SYNC:
                    if (comma) state_next = COMMA_DETECT_1;
                COMMA_DETECT_1:
                    state_next = data ? ACQUIRE_SYNC_1 : LOSS_OF_SYNC;
                COMMA_DETECT_2:
                    state_next = data ? ACQUIRE_SYNC_2 : LOSS_OF_SYNC;
                COMMA_DETECT_3:
                    state_next = data ? SYNC_ACQUIRED_1 : LOSS_OF_SYNC;
                // A comma that is not cgbad is necessarily in an even slot
                ACQUIRE_SYNC_1:
                    if (cgbad)      state_next = LOSS_OF_SYNC;
                    else if (comma) state_next = COMMA_DETECT_2;
                ACQUIRE_SYNC_2:
                    if (cgbad)      state_next = LOSS_OF_SYNC;
                    else if (comma) state_next = COMMA_DETECT_3;
                SYNC_ACQUIRED_1:
                    if (cgbad) state_next = SYNC_ACQUIRED_2;
                SYNC_ACQUIRED_2:
                    state_next = cgbad ? SYNC_ACQUIRED_3 : SYNC_ACQUIRED_2A;
                SYNC_ACQUIRED_3:
                    state_next = cgbad ? SYNC_ACQUIRED_4 : SYNC_ACQUIRED_3A;
                SYNC_ACQUIRED_4:
                    state_next = cgbad ? LOSS_OF_SYNC : SYNC_ACQUIRED_4A;
                SYNC_ACQUIRED_2A:
                    if (cgbad)                         state_next = SYNC_ACQUIRED_3;
                    else if (good_cgs == GOOD_CGS_MAX) state_next = SYNC_ACQUIRED_1;
                SYNC_ACQUIRED_3A:
                    if (cgbad)                         state_next = SYNC_ACQUIRED_4;
                    else if (good_cgs == GOOD_CGS_MAX) state_next = SYNC_ACQUIRED_2;
                SYNC_ACQUIRED_4A:
                    if (cgbad)                         state_next = LOSS_OF_SYNC;
                    else if (good_cgs == GOOD_CGS_MAX) state_next = SYNC_ACQUIRED_3;
                default:
                    state_next = LOSS_OF_SYNC;
            endcase
        end
    end

    always_comb begin
        rx_even_next  = is_comma_detect(state_next) ? 1'b1 : ~rx_even_q;
        status_next   = is_sync_acquired(state_next);
        good_cgs_next = '0;
        if (is_good_run(state_next)) begin
            if (!is_good_run(state)) begin
                good_cgs_next = 2'd1;
            end else if (good_cgs != GOOD_CGS_MAX) begin
                good_cgs_next = good_cgs + 2'd1;
            end else begin
                good_cgs_next = good_cgs;
            end
        end
    end

    always_ff @(posedge GTX_CLK or posedge mr_main_reset) begin
        if (mr_main_reset) begin
            good_cgs   <= '0;
            rx_even_q  <= 1'b0;
            status_q   <= 1'b0;
            rx_comma_q <= 1'b0;
            cg_out_q   <= '0;
        end else begin
            good_cgs   <= good_cgs_next;
            rx_even_q  <= rx_even_next;
            status_q   <= status_next;
            rx_comma_q <= comma;
            cg_out_q   <= rx.rx_code_group;
        end
    end

    assign rx.code_sync_status  = status_q;
    assign rx.rx_even           = rx_even_q;
    assign rx.rx_comma          = rx_comma_q;
    assign rx.rx_code_group_out = cg_out_q;

endmodule

// File: tb/tb_pcs_sync.sv
// Bench for pcs_sync: vector table, directed corner sequences and a random
// stream compared against a counter-based model of the sync rules.
module tb_pcs_sync;
    import pcs_sync_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;

    pcs_sync_if bus ();

    pcs_sync dut (
        .GTX_CLK       (clk),
        .mr_main_reset (rst),
        .rx            (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: phase 0 = hunting, 1 = comma seen, 2 = acquiring
    bit          m_sync;
    int unsigned m_phase;
    int unsigned m_commas;
    int unsigned m_nbad;
    int unsigned m_run;
    bit          m_even;
    bit          m_comma;
    logic [9:0]  m_out;

    task automatic model_reset();
        m_sync = 0; m_phase = 0; m_commas = 0; m_nbad = 0; m_run = 0;
        m_even = 0; m_comma = 0; m_out = '0;
    endtask

    task automatic model_lose();
        m_sync = 0; m_phase = 0; m_commas = 0; m_nbad = 0; m_run = 0;
    endtask

    task automatic model_step(input logic sd, input logic [9:0] cg, input logic inv);
        logic [9:0] t;
        bit is_comma, bad, set_even;
        t = cg;
        is_comma = (t[9:3] == 7'b0011111) || (t[9:3] == 7'b1100000);
        bad = inv || (is_comma && m_even);
        set_even = 0;
        if (!sd) begin
            model_lose();
        end else if (m_sync) begin
            if (bad) begin
                m_nbad++;
                m_run = 0;
                if (m_nbad == 4) model_lose();
            end else if (m_nbad > 0) begin
                m_run++;
                if (m_run == 4) begin
                    m_nbad--;
                    m_run = 0;
                end
            end
        end else if (m_phase == 0) begin
            if (is_comma) begin
                m_phase = 1; m_commas = 1; set_even = 1;
            end
        end else if (m_phase == 1) begin
            if (!is_comma && !inv) begin
                if (m_commas == 3) begin
                    m_sync = 1; m_phase = 0; m_nbad = 0; m_run = 0;
                end else begin
                    m_phase = 2;
                end
            end else begin
                model_lose();
            end
        end else begin
            if (bad) begin
                model_lose();
            end else if (is_comma) begin
                m_commas++; m_phase = 1; set_even = 1;
            end
        end
        m_even  = set_even ? 1'b1 : !m_even;
        m_comma = is_comma;
        m_out   = cg;
    endtask

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic sd, input logic [9:0] cg, input logic inv);
        bus.signal_detect = sd;
        bus.rx_code_group = cg;
        bus.cg_invalid    = inv;
        @(posedge clk);
        #1;
        model_step(sd, cg, inv);
    endtask

    task automatic cmp_model(input string tag);
        check({tag, ".status"}, {9'b0, bus.code_sync_status}, {9'b0, m_sync});
        check({tag, ".even"},   {9'b0, bus.rx_even},          {9'b0, m_even});
        check({tag, ".comma"},  {9'b0, bus.rx_comma},         {9'b0, m_comma});
        check({tag, ".cg_out"}, bus.rx_code_group_out,        m_out);
    endtask

    task automatic step(input string tag, input logic sd, input logic [9:0] cg, input logic inv);
        drive(sd, cg, inv);
        cmp_model(tag);
    endtask

    task automatic acquire();
        step("acq_flush", 1'b0, D16_2_RDP, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step("acq_k", 1'b1, K28_5_RDN, 1'b0);
            step("acq_d", 1'b1, D16_2_RDP, 1'b0);
        end
        check("acq_status", {9'b0, bus.code_sync_status}, 10'd1);
    endtask

    typedef struct {
        logic       sd;
        logic [9:0] cg;
        logic       inv;
        logic       st;
        logic       ev;
        logic       cm;
    } vec_t;

    vec_t vecs[16];

    initial begin
        logic [9:0] rcg;
        logic       rsd;
        logic       rinv;
        bit         phase;

        n_checks = 0;
        n_err    = 0;
        phase    = 0;

        //              sd    cg         inv   status even  comma
        vecs[0]  = '{1'b1, K28_5_RDN, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[1]  = '{1'b1, D16_2_RDP, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, K28_5_RDN, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[3]  = '{1'b1, D16_2_RDP, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, K28_5_RDN, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{1'b1, D16_2_RDP, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, K28_5_RDN, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, D16_2_RDP, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, D16_2_RDN, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, D16_2_RDN, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b1, D16_2_RDN, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{1'b1, D16_2_RDN, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, D16_2_RDP, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b1, K28_5_RDP, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[14] = '{1'b1, K28_5_RDP, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{1'b0, K28_5_RDN, 1'b0, 1'b0, 1'b1, 1'b1};

        rst = 1'b1;
        bus.signal_detect = 1'b0;
        bus.rx_code_group = '0;
        bus.cg_invalid    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset.status", {9'b0, bus.code_sync_status}, 10'd0);
        check("reset.even",   {9'b0, bus.rx_even},          10'd0);
        check("reset.comma",  {9'b0, bus.rx_comma},         10'd0);
        check("reset.cg_out", bus.rx_code_group_out,        10'h000);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].sd, vecs[i].cg, vecs[i].inv);
            check($sformatf("vec%0d.status", i), {9'b0, bus.code_sync_status}, {9'b0, vecs[i].st});
            check($sformatf("vec%0d.even", i),   {9'b0, bus.rx_even},          {9'b0, vecs[i].ev});
            check($sformatf("vec%0d.comma", i),  {9'b0, bus.rx_comma},         {9'b0, vecs[i].cm});
            check($sformatf("vec%0d.cg_out", i), bus.rx_code_group_out,        vecs[i].cg);
        end

        // Hysteresis: one bad retired by four good, then three bad keep sync
        acquire();
        step("hys_bad", 1'b1, D16_2_RDN, 1'b1);
        for (int i = 0; i < 4; i++) step("hys_good", 1'b1, D16_2_RDP, 1'b0);
        for (int i = 0; i < 3; i++) step("hys_bad3", 1'b1, D16_2_RDN, 1'b1);
        check("hys_hold", {9'b0, bus.code_sync_status}, 10'd1);
        step("hys_last", 1'b1, D16_2_RDN, 1'b1);
        check("hys_drop", {9'b0, bus.code_sync_status}, 10'd0);

        // Comma in an odd slot counts as one bad group
        acquire();
        step("mis_even", 1'b1, K28_5_RDN, 1'b0);
        step("mis_odd",  1'b1, K28_5_RDN, 1'b0);
        check("mis_hold", {9'b0, bus.code_sync_status}, 10'd1);
        step("mis_bad", 1'b1, D16_2_RDN, 1'b1);
        step("mis_bad", 1'b1, D16_2_RDN, 1'b1);
        check("mis_sa4", {9'b0, bus.code_sync_status}, 10'd1);
        step("mis_bad", 1'b1, D16_2_RDN, 1'b1);
        check("mis_drop", {9'b0, bus.code_sync_status}, 10'd0);

        // Signal loss for one cycle, then a full six-group reacquisition
        acquire();
        step("sig_loss", 1'b0, D16_2_RDP, 1'b0);
        check("sig_drop", {9'b0, bus.code_sync_status}, 10'd0);
        for (int i = 0; i < 5; i++)
            step("sig_reacq", 1'b1, (i % 2 == 0) ? K28_5_RDN : D16_2_RDP, 1'b0);
        check("sig_not_yet", {9'b0, bus.code_sync_status}, 10'd0);
        step("sig_reacq", 1'b1, D16_2_RDP, 1'b0);
        check("sig_back", {9'b0, bus.code_sync_status}, 10'd1);

        // Asynchronous reset mid-stream
        acquire();
        #3;
        rst = 1'b1;
        #1;
        check("arst.status", {9'b0, bus.code_sync_status}, 10'd0);
        check("arst.even",   {9'b0, bus.rx_even},          10'd0);
        check("arst.comma",  {9'b0, bus.rx_comma},         10'd0);
        check("arst.cg_out", bus.rx_code_group_out,        10'h000);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step("arst_resume", 1'b1, D16_2_RDP, 1'b0);
        step("arst_comma",  1'b1, K28_5_RDP, 1'b0);

        // Random stream, mostly /I/-like so sync is reached and disturbed
        for (int i = 0; i < 3000; i++) begin
            rsd  = ($urandom_range(0, 149) != 0);
            rinv = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 99) < 88) begin
                if (phase) rcg = $urandom_range(0, 1) ? D16_2_RDP : D16_2_RDN;
                else       rcg = $urandom_range(0, 1) ? K28_5_RDN : K28_5_RDP;
                phase = !phase;
            end else begin
                rcg = 10'($urandom);
            end
            step("rand", rsd, rcg, rinv);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/pcs_sync.md
# pcs_sync

Receive-side code-group synchronization block for the 1000BASE-X PCS. It consumes the 10-bit code groups produced by the transmit path (in loopback), or by the PMA receiver, one per clock. It detects /COMMA/ alignment, acquires and tracks sync per the Clause 36 synchronization state machine, and forwards code groups with even/odd tagging to the receive state machine.

## Interface
Parameters:
- none; widths fixed by 8B/10B.

Ports:
- GTX_CLK  in  1  clock; one code group per rising edge.
- mr_main_reset  in  1  asynchronous, active-high reset.
- signal_detect  in  1  PMD signal present; low forces loss of sync.
- rx_code_group  in  10  incoming code group, bit order abcdeifghj (bit 9 = a).
- cg_invalid  in  1  from the decode table, same cycle as rx_code_group; 1 = not in the valid table for current running disparity.
- code_sync_status  out  1  1 = sync acquired.
- rx_even  out  1  parity tag of rx_code_group_out; 1 = even slot.
- rx_code_group_out  out  10  registered copy of rx_code_group.
- rx_comma  out  1  rx_code_group_out is a comma.

## Operation
- Comma: rx_code_group[9:3] == 7'b0011111 or 7'b1100000.
- cgbad = cg_invalid OR (comma AND current slot odd).
- cggood = NOT cgbad.
- Slot parity: in LOSS_OF_SYNC, rx_even toggles every cycle. Entering COMMA_DETECT_x sets rx_even=1 for the comma. Every other state toggles rx_even.
- States and transitions (evaluated per code group):
  - LOSS_OF_SYNC: comma & signal_detect -> COMMA_DETECT_1; else stay.
  - COMMA_DETECT_k (k=1..3), next group:
    - data (not comma, not invalid) -> ACQUIRE_SYNC_k (k=3: SYNC_ACQUIRED_1).
    - else -> LOSS_OF_SYNC.
  - ACQUIRE_SYNC_k (k=1,2):
    - cgbad -> LOSS_OF_SYNC.
    - comma in even slot -> COMMA_DETECT_k+1.
    - else stay.
  - SYNC_ACQUIRED_1: cgbad -> SYNC_ACQUIRED_2; else stay.
  - SYNC_ACQUIRED_n (n=2..4):
    - cgbad -> SYNC_ACQUIRED_n+1 (n=4: LOSS_OF_SYNC).
    - cggood -> SYNC_ACQUIRED_nA with good_cgs=1.
  - SYNC_ACQUIRED_nA:
    - cggood & good_cgs==3 -> SYNC_ACQUIRED_n-1 (2A -> SYNC_ACQUIRED_1).
    - cggood otherwise -> good_cgs+1, stay.
    - cgbad -> SYNC_ACQUIRED_n+1 (4A -> LOSS_OF_SYNC).
- Net effect: four consecutive good groups retire one bad; four net bad groups lose sync.
- code_sync_status = 1 in every SYNC_ACQUIRED_* state, 0 elsewhere.
- signal_detect = 0 in any state -> LOSS_OF_SYNC. This overrides all other transitions.
- good_cgs: 2-bit, saturates at 3, cleared on every non-nA state.

## Timing
- All outputs registered. rx_code_group_out, rx_comma and rx_even are one cycle behind rx_code_group.
- code_sync_status reflects the state after consuming the group now shown on rx_code_group_out.
- Reset values:
  - state = LOSS_OF_SYNC.
  - code_sync_status = 0, rx_even = 0, rx_code_group_out = 10'h000, rx_comma = 0, good_cgs = 0.
- Reset mid-operation: immediate return to the reset values; the first edge after release resumes from LOSS_OF_SYNC.
- Simultaneous signal_detect drop and comma: loss wins.
- Simultaneous cg_invalid and comma: the group is cgbad.

## Structure
- Shared PCS package holds:
  - state encoding (13 states);
  - comma pattern constants 7'b0011111 and 7'b1100000;
  - K28.5 constants 10'h0FA (RD-) and 10'h305 (RD+);
  - D16.2 constants 10'h1B5 (RD-) and 10'h245 (RD+).
- The comma detector is the one natural sub-module, pcs_comma_detect: combinational, 10 bits in, 1 bit out. It is reused by the receive state machine.
- FSM, good_cgs counter and output registers stay in pcs_sync.

## Test plan
- Reset: assert mr_main_reset mid-stream -> all outputs 0 in the same cycle; state LOSS_OF_SYNC.
- Acquisition:
  - Stimulus: signal_detect=1, repeating /I2/ (10'h0FA, 10'h245), comma first on edge 0.
  - Required: code_sync_status rises after edge 5; rx_even=1 on every 10'h0FA output.
- Loss:
  - Stimulus: in sync, cg_invalid=1 on 4 consecutive groups.
  - Required: code_sync_status stays 1 after bads 1-3 and falls after the 4th.
- Hysteresis:
  - Stimulus: in sync, 1 bad, 4 good, then 3 bad.
  - Required: code_sync_status stays 1 (state SYNC_ACQUIRED_4). One further bad drops it to 0.
- Misaligned comma: in sync, 10'h0FA presented in an odd slot -> treated as cgbad; state SYNC_ACQUIRED_2, status stays 1.
- Signal loss: in sync, signal_detect=0 for one cycle -> code_sync_status 0 after that edge; reacquisition needs a fresh 6-group sequence.
